serial_adder_ctrl: RTL and testbench

//  Bit-serial multi-bit adder controller: accepts two WIDTH-bit operands via

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_ctrl_if.sv | 47 ++++
 rtl/full_adder_slice.sv | 28 ++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 265 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// overflow exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow;
`endif

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry,
    input  busy, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry,
    output busy, overflow
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry,
    input  busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry,
    output busy
  );
`endif

endinterface

// File: rtl/full_adder_slice.sv
// One-bit full adder from two half adders and an OR.
module full_adder_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (cin_i),
    .s_o (sum_o),
    .c_o (c1)
  );

  assign cout_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice, LSB first.
// Optional signed overflow flag via SERIAL_ADDER_OVF_EN.
import serial_adder_pkg::*;

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             fa_s, fa_co;

  full_adder_slice u_fa (
    .a_i    (a_q[cnt_q]),
    .b_i    (b_q[cnt_q]),
    .cin_i  (c_q),
    .sum_o  (fa_s),
    .cout_o (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[cnt_q] = fa_s;
        c_d          = fa_co;
        // counter parks on the last bit; accept re-zeroes it
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.carry     = c_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // carry into the MSB is c_q on the final slice cycle
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state_q == IDLE && bus.in_valid)
      ovf_q <= 1'b0;
    else if (state_q == ADD && cnt_q == LAST)
      ovf_q <= c_q ^ fa_co;
  end

  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic ci);
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    bus.cin      = ci;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~x;
    bus.b        = ~y;
    bus.cin      = ~ci;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.sum !== 8'h00) begin
      errors++;
      $display("FAIL rst_sum: got %h want 00", bus.sum);
    end
    checks++;
    if (bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL rst_carry: got %b want 0", bus.carry);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf: got %b want 0", bus.overflow);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'hA5};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h01, 8'h5A};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h80, 8'h00};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef SERIAL_ADDER_OVF_EN
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
    int n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vc[i]);
      wait_valid(n);
      checks++;
      if (n !== 8) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d want 8", i, n);
      end
      checks++;
      if (bus.sum !== es[i]) begin
        errors++;
        $display("FAIL vec%0d_sum: got %h want %h", i, bus.sum, es[i]);
      end
      checks++;
      if (bus.carry !== ec[i]) begin
        errors++;
        $display("FAIL vec%0d_carry: got %b want %b", i, bus.carry, ec[i]);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_done_flags: got busy=%b rdy=%b want 1 0",
                 i, bus.busy, bus.in_ready);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (bus.overflow !== eo[i]) begin
        errors++;
        $display("FAIL vec%0d_ovf: got %b want %b", i, bus.overflow, eo[i]);
      end
`endif
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_release: got vld=%b rdy=%b want 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    wait_valid(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 8", n);
    end
    bus.in_valid = 1'b1;
    bus.a        = 8'h01;
    bus.b        = 8'h01;
    bus.cin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 8'h46 ||
          bus.carry !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b sum=%h c=%b rdy=%b want 1 46 0 0",
                 i, bus.out_valid, bus.sum, bus.carry, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: got rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 8 || bus.sum !== 8'h02 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_op: got lat=%0d sum=%h c=%b want 8 02 0",
               n, bus.sum, bus.carry);
    end
    tick();
  endtask

  task automatic test_ignore_during_add();
    int n;
    bus.out_ready = 1'b1;
    send(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.cin      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL ign_latency: got %0d want 5", n);
    end
    checks++;
    if (bus.sum !== 8'h30 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL ign_result: got sum=%h c=%b want 30 0",
               bus.sum, bus.carry);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: got busy=%b vld=%b want 0 0",
               bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_add();
    int n;
    bus.out_ready = 1'b1;
    send(8'h55, 8'h55, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rma_flags: got rdy=%b vld=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.sum !== 8'h00 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL rma_clear: got sum=%h c=%b want 00 0",
               bus.sum, bus.carry);
    end
    send(8'h03, 8'h04, 1'b0);
    wait_valid(n);
    checks++;
    if (n !== 8 || bus.sum !== 8'h07 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL rma_next_op: got lat=%0d sum=%h c=%b want 8 07 0",
               n, bus.sum, bus.carry);
    end
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_ignore_during_add();
    test_reset_mid_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
